multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the LEGv8 core. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK using the decoded control bits from the control unit. Fetch and data accesses share one memory port through a req/ack handshake. It issues the IR, PC, register-file and flag write enables, and traps memory timeouts and illegal decodes into a sticky FAULT state.

---
 rtl/multicycle_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 instruction sequencer.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// shares one memory port between fetch and data accesses through a req/ack
// handshake, and parks in a sticky FAULT state on a memory timeout or an
// illegal decode (load and store at the same time).
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,  // legal range 1..255
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               dec_mem_read,
  input  logic               dec_mem_write,
  input  logic               dec_reg_write,
  input  logic               dec_set_flags,
  input  logic               dec_branch,
  input  logic               branch_taken,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               reg_we,
  output logic               flags_we,
  output logic [2:0]         state,
  output logic [1:0]         fault_code,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd7
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  // Counter value seen on the last req cycle that may still accept an ack.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  // Registered state
  state_t               state_r;
  logic [1:0]           fault_code_r;
  logic [COUNT_W-1:0]   instr_count_r;
  logic [7:0]           tmo_cnt_r;
  logic                 lat_mem_read_r;
  logic                 lat_mem_write_r;
  logic                 lat_reg_write_r;
  logic                 lat_set_flags_r;
  logic                 lat_branch_r;
  logic                 taken_r;

  // Combinational decode of the registered state
  state_t               next_state_s;
  logic [1:0]           fault_code_next_s;
  logic                 retire_s;
  logic                 mem_req_s;
  logic                 mem_we_s;
  logic                 mem_addr_sel_s;
  logic                 ir_we_s;
  logic                 pc_sel_s;
  logic                 reg_we_s;
  logic                 flags_we_s;
  logic                 tmo_expire_s;

  // The current request has used its last allowed cycle without an ack.
  assign tmo_expire_s = (tmo_cnt_r == TMO_LAST);

  // State register; reset drops every strobe at once since they decode from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and strobe decode; retire covers the last cycle of each instruction.
  always_comb begin
    next_state_s      = state_r;
    fault_code_next_s = fault_code_r;
    retire_s          = 1'b0;
    mem_req_s         = 1'b0;
    mem_we_s          = 1'b0;
    mem_addr_sel_s    = 1'b0;
    ir_we_s           = 1'b0;
    pc_sel_s          = 1'b0;
    reg_we_s          = 1'b0;
    flags_we_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (run) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b0;
        if (mem_ack) begin
          ir_we_s      = 1'b1;
          next_state_s = ST_DECODE;
        end else if (tmo_expire_s) begin
          next_state_s      = ST_FAULT;
          fault_code_next_s = FC_TIMEOUT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (dec_mem_read && dec_mem_write) begin
          next_state_s      = ST_FAULT;
          fault_code_next_s = FC_ILLEGAL;
        end else begin
          next_state_s = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        flags_we_s = lat_set_flags_r;
        if (lat_mem_read_r || lat_mem_write_r) begin
          next_state_s = ST_MEMORY;
        end else if (lat_reg_write_r) begin
          next_state_s = ST_WRITEBACK;
        end else begin
          // Retiring here: the branch condition is still only available live.
          retire_s     = 1'b1;
          pc_sel_s     = lat_branch_r & branch_taken;
          next_state_s = run ? ST_FETCH : ST_IDLE;
        end
      end

      ST_MEMORY: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_we_s       = lat_mem_write_r;
        if (mem_ack) begin
          if (lat_mem_read_r) begin
            next_state_s = ST_WRITEBACK;
          end else begin
            retire_s     = 1'b1;
            pc_sel_s     = lat_branch_r & taken_r;
            next_state_s = run ? ST_FETCH : ST_IDLE;
          end
        end else if (tmo_expire_s) begin
          next_state_s      = ST_FAULT;
          fault_code_next_s = FC_TIMEOUT;
        end else begin
          next_state_s = ST_MEMORY;
        end
      end

      ST_WRITEBACK: begin
        reg_we_s     = 1'b1;
        retire_s     = 1'b1;
        pc_sel_s     = lat_branch_r & taken_r;
        next_state_s = run ? ST_FETCH : ST_IDLE;
      end

      ST_FAULT: begin
        next_state_s = ST_FAULT;
      end

      default: begin
        // Unused encoding: treat as corruption and park safely.
        next_state_s = ST_FAULT;
      end
    endcase
  end

  // Fault code is captured on the transition into FAULT and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_code_r <= FC_NONE;
    end else begin
      fault_code_r <= fault_code_next_s;
    end
  end

  // Request wait counter: cleared on entry to a requesting state, counts unacked cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 8'd0;
    end else if (next_state_s != state_r) begin
      tmo_cnt_r <= 8'd0;
    end else if (mem_req_s && !mem_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Capture the control-unit decode at the end of DECODE for the rest of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_mem_read_r  <= 1'b0;
      lat_mem_write_r <= 1'b0;
      lat_reg_write_r <= 1'b0;
      lat_set_flags_r <= 1'b0;
      lat_branch_r    <= 1'b0;
    end else if (state_r == ST_DECODE) begin
      lat_mem_read_r  <= dec_mem_read;
      lat_mem_write_r <= dec_mem_write;
      lat_reg_write_r <= dec_reg_write;
      lat_set_flags_r <= dec_set_flags;
      lat_branch_r    <= dec_branch;
    end else begin
      lat_mem_read_r  <= lat_mem_read_r;
      lat_mem_write_r <= lat_mem_write_r;
      lat_reg_write_r <= lat_reg_write_r;
      lat_set_flags_r <= lat_set_flags_r;
      lat_branch_r    <= lat_branch_r;
    end
  end

  // Hold the branch condition from EXECUTE for retirement in a later state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_r <= 1'b0;
    end else if (state_r == ST_EXECUTE) begin
      taken_r <= branch_taken;
    end else begin
      taken_r <= taken_r;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_r <= '0;
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + COUNT_W'(1);
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  assign mem_req      = mem_req_s;
  assign mem_we       = mem_we_s;
  assign mem_addr_sel = mem_addr_sel_s;
  assign ir_we        = ir_we_s;
  assign pc_we        = retire_s;
  assign pc_sel       = pc_sel_s;
  assign reg_we       = reg_we_s;
  assign flags_we     = flags_we_s;
  assign state        = state_r;
  assign fault_code   = fault_code_r;
  assign instr_count  = instr_count_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with MEM_TIMEOUT=4.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        dec_mem_read = 1'b0;
  logic        dec_mem_write = 1'b0;
  logic        dec_reg_write = 1'b0;
  logic        dec_set_flags = 1'b0;
  logic        dec_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we, flags_we;
  logic [2:0]  state;
  logic [1:0]  fault_code;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;

  // Strobe vector: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we, flags_we}
  logic [7:0] strb;
  assign strb = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we, flags_we};

  multicycle_sequencer #(.MEM_TIMEOUT(4), .COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_set_flags(dec_set_flags),
    .dec_branch(dec_branch), .branch_taken(branch_taken), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .flags_we(flags_we), .state(state), .fault_code(fault_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic clear_dec();
    dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b0;
    dec_set_flags = 1'b0; dec_branch = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    if (state !== 3'd0 || strb !== 8'b0000_0000) begin failures++; $display("FAIL reset_state: state=%0d strb=%b want state=0 strb=00000000", state, strb); end
    checks++;
    if (fault_code !== 2'b00 || instr_count !== 32'd0) begin failures++; $display("FAIL reset_regs: fault=%b count=%0d want fault=00 count=0", fault_code, instr_count); end
    checks++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk); run = 1'b1; #1;
    if (state !== 3'd0 || strb !== 8'b0000_0000) begin failures++; $display("FAIL add_idle: state=%0d strb=%b want state=0 strb=00000000", state, strb); end
    checks++;
    @(negedge clk); mem_ack = 1'b1; #1;
    if (state !== 3'd1 || strb !== 8'b1001_0000) begin failures++; $display("FAIL add_fetch: state=%0d strb=%b want state=1 strb=10010000", state, strb); end
    checks++;
    @(negedge clk); mem_ack = 1'b0; dec_reg_write = 1'b1; #1;
    if (state !== 3'd2 || strb !== 8'b0000_0000) begin failures++; $display("FAIL add_decode: state=%0d strb=%b want state=2 strb=00000000", state, strb); end
    checks++;
    @(negedge clk); clear_dec(); #1;
    if (state !== 3'd3 || strb !== 8'b0000_0000) begin failures++; $display("FAIL add_execute: state=%0d strb=%b want state=3 strb=00000000", state, strb); end
    checks++;
    @(negedge clk); #1;
    if (state !== 3'd5 || strb !== 8'b0000_1010 || instr_count !== 32'd0) begin failures++; $display("FAIL add_wb: state=%0d strb=%b count=%0d want state=5 strb=00001010 count=0", state, strb, instr_count); end
    checks++;
    @(negedge clk); #1;
    if (state !== 3'd1 || instr_count !== 32'd1) begin failures++; $display("FAIL add_retire: state=%0d count=%0d want state=1 count=1", state, instr_count); end
    checks++;
  endtask

  task automatic test_load_wait();
    @(negedge clk); mem_ack = 1'b1; #1;
    if (state !== 3'd1 || strb !== 8'b1001_0000) begin failures++; $display("FAIL ld_fetch: state=%0d strb=%b want state=1 strb=10010000", state, strb); end
    checks++;
    @(negedge clk); mem_ack = 1'b0; dec_mem_read = 1'b1; dec_reg_write = 1'b1; #1;
    if (state !== 3'd2) begin failures++; $display("FAIL ld_decode: state=%0d want 2", state); end
    checks++;
    @(negedge clk); clear_dec(); #1;
    if (state !== 3'd3 || strb !== 8'b0000_0000) begin failures++; $display("FAIL ld_execute: state=%0d strb=%b want state=3 strb=00000000", state, strb); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = (i == 2); #1;
      if (state !== 3'd4 || strb !== 8'b1010_0000) begin failures++; $display("FAIL ld_mem%0d: state=%0d strb=%b want state=4 strb=10100000", i, state, strb); end
      checks++;
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    if (state !== 3'd5 || strb !== 8'b0000_1010) begin failures++; $display("FAIL ld_wb: state=%0d strb=%b want state=5 strb=00001010", state, strb); end
    checks++;
    @(negedge clk); #1;
    if (state !== 3'd1 || instr_count !== 32'd2) begin failures++; $display("FAIL ld_retire: state=%0d count=%0d want state=1 count=2", state, instr_count); end
    checks++;
  endtask

  // Store whose ack arrives on the last allowed (4th) request cycle.
  task automatic test_store_boundary();
    @(negedge clk); mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; dec_mem_write = 1'b1; #1;
    @(negedge clk); clear_dec(); #1;
    if (state !== 3'd3 || strb !== 8'b0000_0000) begin failures++; $display("FAIL st_execute: state=%0d strb=%b want state=3 strb=00000000", state, strb); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (state !== 3'd4 || strb !== 8'b1110_0000) begin failures++; $display("FAIL st_wait%0d: state=%0d strb=%b want state=4 strb=11100000", i, state, strb); end
      checks++;
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    if (state !== 3'd4 || strb !== 8'b1110_1000 || instr_count !== 32'd2) begin failures++; $display("FAIL st_ack: state=%0d strb=%b count=%0d want state=4 strb=11101000 count=2", state, strb, instr_count); end
    checks++;
    @(negedge clk); mem_ack = 1'b0; #1;
    if (state !== 3'd1 || instr_count !== 32'd3 || fault_code !== 2'b00) begin failures++; $display("FAIL st_retire: state=%0d count=%0d fault=%b want state=1 count=3 fault=00", state, instr_count, fault_code); end
    checks++;
  endtask

  task automatic test_cbz();
    @(negedge clk); mem_ack = 1'b1; #1;
    @(negedge clk); mem_ack = 1'b0; dec_set_flags = 1'b1; dec_branch = 1'b1; #1;
    if (state !== 3'd2) begin failures++; $display("FAIL cbz_decode: state=%0d want 2", state); end
    checks++;
    @(negedge clk); dec_set_flags = 1'b0; dec_branch = 1'b0; branch_taken = 1'b1; run = 1'b0; #1;
    if (state !== 3'd3 || strb !== 8'b0000_1101) begin failures++; $display("FAIL cbz_execute: state=%0d strb=%b want state=3 strb=00001101", state, strb); end
    checks++;
    @(negedge clk); branch_taken = 1'b0; #1;
    if (state !== 3'd0 || instr_count !== 32'd4 || strb !== 8'b0000_0000) begin failures++; $display("FAIL cbz_retire: state=%0d count=%0d strb=%b want state=0 count=4 strb=00000000", state, instr_count, strb); end
    checks++;
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0; #1;
    if (state !== 3'd1 || mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre: state=%0d mem_req=%b want state=1 mem_req=1", state, mem_req); end
    checks++;
    #1; rst_n = 1'b0; #1;
    if (mem_req !== 1'b0 || state !== 3'd0 || instr_count !== 32'd0) begin failures++; $display("FAIL rst_async: mem_req=%b state=%0d count=%0d want 0 0 0", mem_req, state, instr_count); end
    checks++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    @(negedge clk); run = 1'b1; #1;
    if (state !== 3'd0) begin failures++; $display("FAIL to_idle: state=%0d want 0", state); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (state !== 3'd1 || strb !== 8'b1000_0000) begin failures++; $display("FAIL to_req%0d: state=%0d strb=%b want state=1 strb=10000000", i, state, strb); end
      checks++;
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    if (state !== 3'd7 || fault_code !== 2'b01 || strb !== 8'b0000_0000) begin failures++; $display("FAIL to_fault: state=%0d fault=%b strb=%b want state=7 fault=01 strb=00000000", state, fault_code, strb); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (state !== 3'd7 || strb !== 8'b0000_0000 || fault_code !== 2'b01 || instr_count !== 32'd0) begin failures++; $display("FAIL to_sticky%0d: state=%0d strb=%b fault=%b count=%0d want 7 00000000 01 0", i, state, strb, fault_code, instr_count); end
      checks++;
    end
    mem_ack = 1'b0; run = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; run = 1'b1; #1;
    if (state !== 3'd0 || fault_code !== 2'b00) begin failures++; $display("FAIL il_reset: state=%0d fault=%b want state=0 fault=00", state, fault_code); end
    checks++;
    @(negedge clk); mem_ack = 1'b1; #1;
    if (state !== 3'd1 || strb !== 8'b1001_0000) begin failures++; $display("FAIL il_fetch: state=%0d strb=%b want state=1 strb=10010000", state, strb); end
    checks++;
    @(negedge clk); mem_ack = 1'b0; dec_mem_read = 1'b1; dec_mem_write = 1'b1; #1;
    if (state !== 3'd2 || strb !== 8'b0000_0000) begin failures++; $display("FAIL il_decode: state=%0d strb=%b want state=2 strb=00000000", state, strb); end
    checks++;
    @(negedge clk); clear_dec(); #1;
    if (state !== 3'd7 || fault_code !== 2'b10 || strb !== 8'b0000_0000 || instr_count !== 32'd0) begin failures++; $display("FAIL il_fault: state=%0d fault=%b strb=%b count=%0d want 7 10 00000000 0", state, fault_code, strb, instr_count); end
    checks++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      if (state !== 3'd7 || mem_req !== 1'b0 || fault_code !== 2'b10) begin failures++; $display("FAIL il_sticky%0d: state=%0d mem_req=%b fault=%b want 7 0 10", i, state, mem_req, fault_code); end
      checks++;
    end
    mem_ack = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store_boundary();
    test_cbz();
    test_reset_mid_fetch();
    test_timeout();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
